// File: rtl/decode_dispatch.sv
// Buffered MIPS-subset decoder: FIFO of fetched words, head decode, issue to Int/LS/Mult queues.
// Optional feature: define DECODE_MULT_EN to decode MULT and drive Dispatch_en_Mult.
module decode_dispatch #(
  parameter int IBUF_DEPTH = 4,
  parameter int CNT_W      = $clog2(IBUF_DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic [31:0]      Inst,
  input  logic             Inst_Valid,
  output logic             Inst_Ready,
  input  logic             Int_Full,
  input  logic             LS_Full,
  input  logic             Mult_Full,
  output logic [3:0]       Dispatch_Opcode,
  output logic [4:0]       Dispatch_Shfamt,
  output logic [31:0]      Dispatch_Imm_LS,
  output logic [4:0]       Dispatch_Rs,
  output logic [4:0]       Dispatch_Rt,
  output logic [4:0]       Dispatch_Rd,
  output logic             Dispatch_Rd_Wr,
  output logic             Dispatch_en_Int,
  output logic             Dispatch_en_LS,
  output logic             Dispatch_en_Mult,
  output logic             Dispatch_Jmp,
  output logic [25:0]      Dispatch_Jmp_Addr,
  output logic             Illegal_Inst,
  output logic [CNT_W-1:0] Buf_Count
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);

  typedef enum logic [1:0] {TGT_NONE, TGT_INT, TGT_LS, TGT_MULT} target_e;

  logic [31:0]      ibuf [IBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, blocked;
  logic [31:0]      head;
  logic [5:0]       op, funct;

  target_e     tgt;
  logic [3:0]  dec_opcode;
  logic [4:0]  dec_shamt, dec_rs, dec_rt, dec_rd;
  logic [31:0] dec_imm;
  logic [25:0] dec_jmp_addr;
  logic        dec_rd_wr, dec_jmp, dec_illegal;

  assign Inst_Ready = (count < CNT_W'(IBUF_DEPTH));
  assign Buf_Count  = count;
  assign push       = Inst_Valid && Inst_Ready && !Flush;
  assign head       = ibuf[rd_ptr];
  assign op         = head[31:26];
  assign funct      = head[5:0];

  always_comb begin
    tgt          = TGT_NONE;
    dec_opcode   = '0;
    dec_shamt    = '0;
    dec_imm      = '0;
    dec_rs       = '0;
    dec_rt       = '0;
    dec_rd       = '0;
    dec_rd_wr    = 1'b0;
    dec_jmp      = 1'b0;
    dec_jmp_addr = '0;
    dec_illegal  = 1'b0;
    if (op == 6'h00) begin
      tgt       = TGT_INT;
      dec_rd_wr = 1'b1;
      case (funct)
        6'h20: dec_opcode = 4'h2;
        6'h21: dec_opcode = 4'h3;
        6'h22: dec_opcode = 4'h6;
        6'h24: dec_opcode = 4'h0;
        6'h25: dec_opcode = 4'h1;
        6'h27: dec_opcode = 4'hC;
        6'h2A: dec_opcode = 4'h7;
        6'h2B: dec_opcode = 4'hA;
        6'h00: dec_opcode = 4'h8;
        6'h02: dec_opcode = 4'h9;
`ifdef DECODE_MULT_EN
        6'h18: begin
          tgt       = TGT_MULT;
          dec_rd_wr = 1'b0;
        end
`endif
        default: begin
          tgt         = TGT_NONE;
          dec_rd_wr   = 1'b0;
          dec_illegal = 1'b1;
        end
      endcase
      if (!dec_illegal) begin
        dec_rs    = head[25:21];
        dec_rt    = head[20:16];
        dec_rd    = head[15:11];
        dec_shamt = head[10:6];
      end
    end else if (op == 6'h02) begin
      dec_jmp      = 1'b1;
      dec_jmp_addr = head[25:0];
    end else begin
      tgt       = TGT_INT;
      dec_rd_wr = 1'b1;
      case (op)
        6'h08: dec_opcode = 4'h2;
        6'h09: dec_opcode = 4'h3;
        6'h0A: dec_opcode = 4'h7;
        6'h0C: dec_opcode = 4'h0;
        6'h0D: dec_opcode = 4'h1;
        6'h04: begin
          dec_opcode = 4'h4;
          dec_rd_wr  = 1'b0;
        end
        6'h05: begin
          dec_opcode = 4'h5;
          dec_rd_wr  = 1'b0;
        end
        6'h23: begin
          tgt        = TGT_LS;
          dec_opcode = 4'h1;
        end
        6'h2B: begin
          tgt        = TGT_LS;
          dec_opcode = 4'h0;
          dec_rd_wr  = 1'b0;
        end
        default: begin
          tgt         = TGT_NONE;
          dec_rd_wr   = 1'b0;
          dec_illegal = 1'b1;
        end
      endcase
      if (!dec_illegal) begin
        dec_rs  = head[25:21];
        dec_rt  = head[20:16];
        dec_rd  = head[20:16];
        // ANDI/ORI are logical ops and take a zero-extended immediate
        dec_imm = (op == 6'h0C || op == 6'h0D) ? {16'h0000, head[15:0]}
                                               : {{16{head[15]}}, head[15:0]};
      end
    end
  end

  // Jumps and illegal words have no target queue, so nothing can hold them back
  always_comb begin
    blocked = 1'b0;
    case (tgt)
      TGT_INT:  blocked = Int_Full;
      TGT_LS:   blocked = LS_Full;
      TGT_MULT: blocked = Mult_Full;
      default:  blocked = 1'b0;
    endcase
  end

  assign pop = (count != '0) && !Flush && !blocked;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) ibuf[wr_ptr] <= Inst;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Dispatch_en_Int   <= 1'b0;
      Dispatch_en_LS    <= 1'b0;
      Dispatch_Jmp      <= 1'b0;
      Illegal_Inst      <= 1'b0;
      Dispatch_Opcode   <= '0;
      Dispatch_Shfamt   <= '0;
      Dispatch_Imm_LS   <= '0;
      Dispatch_Rs       <= '0;
      Dispatch_Rt       <= '0;
      Dispatch_Rd       <= '0;
      Dispatch_Rd_Wr    <= 1'b0;
      Dispatch_Jmp_Addr <= '0;
    end else begin
      Dispatch_en_Int   <= pop && (tgt == TGT_INT);
      Dispatch_en_LS    <= pop && (tgt == TGT_LS);
      Dispatch_Jmp      <= pop && dec_jmp;
      Illegal_Inst      <= pop && dec_illegal;
      Dispatch_Opcode   <= pop ? dec_opcode   : '0;
      Dispatch_Shfamt   <= pop ? dec_shamt    : '0;
      Dispatch_Imm_LS   <= pop ? dec_imm      : '0;
      Dispatch_Rs       <= pop ? dec_rs       : '0;
      Dispatch_Rt       <= pop ? dec_rt       : '0;
      Dispatch_Rd       <= pop ? dec_rd       : '0;
      Dispatch_Rd_Wr    <= pop && dec_rd_wr;
      Dispatch_Jmp_Addr <= pop ? dec_jmp_addr : '0;
    end
  end

`ifdef DECODE_MULT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Dispatch_en_Mult <= 1'b0;
    else        Dispatch_en_Mult <= pop && (tgt == TGT_MULT);
  end
`else
  assign Dispatch_en_Mult = 1'b0;
`endif

endmodule

// File: tb/tb_decode_dispatch.sv
// Bench for decode_dispatch: directed vector table, hand sequences, then random traffic
// checked against a queue-based reference model. Honours DECODE_MULT_EN.
module tb_decode_dispatch;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int VW    = 89 + CNT_W;
`ifdef DECODE_MULT_EN
  localparam bit MULT_ON = 1'b1;
`else
  localparam bit MULT_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n, Flush, Inst_Valid, Inst_Ready, Int_Full, LS_Full, Mult_Full;
  logic [31:0] Inst, Dispatch_Imm_LS;
  logic [3:0] Dispatch_Opcode;
  logic [4:0] Dispatch_Shfamt, Dispatch_Rs, Dispatch_Rt, Dispatch_Rd;
  logic Dispatch_Rd_Wr, Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult;
  logic Dispatch_Jmp, Illegal_Inst;
  logic [25:0] Dispatch_Jmp_Addr;
  logic [CNT_W-1:0] Buf_Count;

  always #5 Clk = ~Clk;

  decode_dispatch #(.IBUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Inst(Inst), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .Int_Full(Int_Full), .LS_Full(LS_Full), .Mult_Full(Mult_Full),
    .Dispatch_Opcode(Dispatch_Opcode), .Dispatch_Shfamt(Dispatch_Shfamt),
    .Dispatch_Imm_LS(Dispatch_Imm_LS), .Dispatch_Rs(Dispatch_Rs), .Dispatch_Rt(Dispatch_Rt),
    .Dispatch_Rd(Dispatch_Rd), .Dispatch_Rd_Wr(Dispatch_Rd_Wr),
    .Dispatch_en_Int(Dispatch_en_Int), .Dispatch_en_LS(Dispatch_en_LS),
    .Dispatch_en_Mult(Dispatch_en_Mult), .Dispatch_Jmp(Dispatch_Jmp),
    .Dispatch_Jmp_Addr(Dispatch_Jmp_Addr), .Illegal_Inst(Illegal_Inst), .Buf_Count(Buf_Count)
  );

  logic [VW-1:0] act_vec;
  assign act_vec = {Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult, Dispatch_Jmp, Illegal_Inst,
                    Dispatch_Opcode, Dispatch_Shfamt, Dispatch_Imm_LS, Dispatch_Rs, Dispatch_Rt,
                    Dispatch_Rd, Dispatch_Rd_Wr, Dispatch_Jmp_Addr, Inst_Ready, Buf_Count};

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] T_NONE = 2'd0, T_INT = 2'd1, T_LS = 2'd2, T_MULT = 2'd3;

  typedef struct packed {
    logic [1:0]  tgt;
    logic        jmp;
    logic        ill;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wr;
    logic [25:0] ja;
  } dec_t;

  typedef struct {
    string         name;
    logic          valid;
    logic [31:0]   inst;
    logic          flush;
    logic          int_full;
    logic          ls_full;
    logic [VW-1:0] expect_vec;
  } vec_t;

  vec_t rows[$];
  logic [31:0] model_q[$];

  logic [5:0] r_functs [11] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h18};
  logic [5:0] i_ops [9]     = '{6'h08, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h23, 6'h2B};

  // Instruction semantics as listed in the ISA mapping tables
  function automatic dec_t refDecode(input logic [31:0] w);
    dec_t d;
    int code;
    d = '0;
    code = -1;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20: code = 2;  6'h21: code = 3;  6'h22: code = 6;  6'h24: code = 0;
        6'h25: code = 1;  6'h27: code = 12; 6'h2A: code = 7;  6'h2B: code = 10;
        6'h00: code = 8;  6'h02: code = 9;
        default: code = -1;
      endcase
      if (code >= 0) begin
        d.tgt = T_INT; d.wr = 1'b1; d.op = code[3:0];
      end else if (w[5:0] == 6'h18 && MULT_ON) begin
        d.tgt = T_MULT;
      end
      if (d.tgt != T_NONE) begin
        d.rs = w[25:21]; d.rt = w[20:16]; d.rd = w[15:11]; d.sh = w[10:6];
      end else d.ill = 1'b1;
    end else if (w[31:26] == 6'h02) begin
      d.jmp = 1'b1; d.ja = w[25:0];
    end else begin
      case (w[31:26])
        6'h08: code = 2; 6'h09: code = 3; 6'h0A: code = 7; 6'h04: code = 4; 6'h05: code = 5;
        6'h0C: code = 0; 6'h0D: code = 1; 6'h23: code = 1; 6'h2B: code = 0;
        default: code = -1;
      endcase
      if (code < 0) d.ill = 1'b1;
      else begin
        d.tgt = (w[31:26] == 6'h23 || w[31:26] == 6'h2B) ? T_LS : T_INT;
        d.op  = code[3:0];
        d.rs  = w[25:21]; d.rt = w[20:16]; d.rd = w[20:16];
        d.wr  = !(w[31:26] == 6'h04 || w[31:26] == 6'h05 || w[31:26] == 6'h2B);
        d.imm = (w[31:26] == 6'h0C || w[31:26] == 6'h0D) ? {16'h0000, w[15:0]}
                                                          : {{16{w[15]}}, w[15:0]};
      end
    end
    return d;
  endfunction

  function automatic logic [VW-1:0] packOut(input dec_t d, input bit issued, input bit rdy,
                                            input logic [CNT_W-1:0] cnt);
    logic [VW-1:0] v;
    v = '0;
    if (issued)
      v = {d.tgt == T_INT, d.tgt == T_LS, d.tgt == T_MULT, d.jmp, d.ill, d.op, d.sh, d.imm,
           d.rs, d.rt, d.rd, d.wr, d.ja, 1'b0, {CNT_W{1'b0}}};
    v[CNT_W] = rdy;
    v[CNT_W-1:0] = cnt;
    return v;
  endfunction

  function automatic logic [VW-1:0] mkExp(input logic [4:0] st, input logic [3:0] op,
                                          input logic [31:0] imm, input logic [15:0] regs,
                                          input logic [25:0] ja, input logic rdy, input int cnt);
    return {st, op, 5'd0, imm, regs, ja, rdy, cnt[CNT_W-1:0]};
  endfunction

  // One clock of the buffer as a plain queue: refuse at full, pop head unless its queue is full
  task automatic modelStep(input bit v, input logic [31:0] w, input bit fl, input bit ifl,
                           input bit lfl, input bit mfl, output logic [VW-1:0] e);
    dec_t d;
    bit issued, accept, blocked;
    d = '0;
    issued = 1'b0;
    if (fl) model_q.delete();
    else begin
      accept = v && (model_q.size() < DEPTH);
      if (model_q.size() > 0) begin
        d = refDecode(model_q[0]);
        blocked = (d.tgt == T_INT && ifl) || (d.tgt == T_LS && lfl) || (d.tgt == T_MULT && mfl);
        if (!blocked) begin
          issued = 1'b1;
          void'(model_q.pop_front());
        end
      end
      if (accept) model_q.push_back(w);
    end
    e = packOut(d, issued, model_q.size() < DEPTH, CNT_W'(model_q.size()));
  endtask

  function automatic logic [31:0] genInst();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 23);
    if (sel < 11) begin
      w[31:26] = 6'h00; w[5:0] = r_functs[sel];
    end else if (sel < 20) w[31:26] = i_ops[sel-11];
    else if (sel < 22) w[31:26] = 6'h02;
    return w;
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] w, input bit fl, input bit ifl,
                               input bit lfl, input bit mfl);
    Inst_Valid = v; Inst = w; Flush = fl; Int_Full = ifl; LS_Full = lfl; Mult_Full = mfl;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [VW-1:0] expect_vec);
    vectors++;
    if (act_vec !== expect_vec) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h", name, act_vec, expect_vec);
    end
  endtask

  task automatic addRow(input string name, input bit v, input logic [31:0] w, input bit fl,
                        input bit ifl, input bit lfl, input logic [VW-1:0] e);
    vec_t r;
    r.name = name; r.valid = v; r.inst = w; r.flush = fl;
    r.int_full = ifl; r.ls_full = lfl; r.expect_vec = e;
    rows.push_back(r);
  endtask

  localparam logic [31:0] ADD_W = 32'h00221820;
  localparam logic [31:0] LDW_W = 32'h8C220010;

  initial begin
    logic [VW-1:0] e;
    logic [31:0] w;
    bit v, fl, ifl, lfl, mfl;

    Rst_n = 1'b0; Flush = 1'b0; Inst_Valid = 1'b0; Inst = '0;
    Int_Full = 1'b0; LS_Full = 1'b0; Mult_Full = 1'b0;
    #12;
    checkOutput("reset_async", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    @(negedge Clk);
    Rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_state", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));

    addRow("push_add",    1'b1, ADD_W,        1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    addRow("issue_add",   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b10000, 4'h2, 32'h0, {5'd1, 5'd2, 5'd3, 1'b1}, 26'h0, 1'b1, 0));
    addRow("push_addi",   1'b1, 32'h2085FFFC, 1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    addRow("issue_addi",  1'b1, 32'h34C7FFFC, 1'b0, 1'b0, 1'b0, mkExp(5'b10000, 4'h2, 32'hFFFFFFFC, {5'd4, 5'd5, 5'd5, 1'b1}, 26'h0, 1'b1, 1));
    addRow("issue_ori",   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b10000, 4'h1, 32'h0000FFFC, {5'd6, 5'd7, 5'd7, 1'b1}, 26'h0, 1'b1, 0));
    for (int i = 1; i <= 4; i++)
      addRow("fill_ldw",  1'b1, LDW_W,        1'b0, 1'b0, 1'b1, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, i < 4, i));
    addRow("push_refused",1'b1, ADD_W,        1'b0, 1'b0, 1'b1, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b0, 4));
    for (int i = 3; i >= 0; i--)
      addRow("drain_ldw", 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b01000, 4'h1, 32'h10, {5'd1, 5'd2, 5'd2, 1'b1}, 26'h0, 1'b1, i));
    addRow("idle",        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    addRow("push_j",      1'b1, 32'h08000100, 1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    addRow("issue_j",     1'b1, 32'hFC000000, 1'b0, 1'b0, 1'b0, mkExp(5'b00010, 4'h0, 32'h0, 16'h0, 26'h100, 1'b1, 1));
    addRow("issue_illegal",1'b0, 32'h0,       1'b0, 1'b0, 1'b0, mkExp(5'b00001, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    addRow("push_stw",    1'b1, 32'hAC698000, 1'b0, 1'b1, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    addRow("issue_stw",   1'b0, 32'h0,        1'b0, 1'b1, 1'b0, mkExp(5'b01000, 4'h0, 32'hFFFF8000, {5'd3, 5'd9, 5'd9, 1'b0}, 26'h0, 1'b1, 0));
    for (int i = 1; i <= 3; i++)
      addRow("queue_add", 1'b1, ADD_W,        1'b0, 1'b1, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, i));
    addRow("flush",       1'b1, ADD_W,        1'b1, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    addRow("after_flush", 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    addRow("push_beq",    1'b1, 32'h1022FFFF, 1'b0, 1'b0, 1'b0, mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    addRow("issue_beq",   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mkExp(5'b10000, 4'h4, 32'hFFFFFFFF, {5'd1, 5'd2, 5'd2, 1'b0}, 26'h0, 1'b1, 0));

    foreach (rows[i]) begin
      applyStimulus(rows[i].valid, rows[i].inst, rows[i].flush, rows[i].int_full, rows[i].ls_full, 1'b0);
      checkOutput(rows[i].name, rows[i].expect_vec);
    end

    // MULT held by Mult_Full when enabled, popped as illegal when not
    applyStimulus(1'b1, 32'h00220018, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mult_push", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (MULT_ON) checkOutput("mult_held", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 1));
    else         checkOutput("mult_illegal", mkExp(5'b00001, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (MULT_ON) checkOutput("mult_issue", mkExp(5'b00100, 4'h0, 32'h0, {5'd1, 5'd2, 5'd0, 1'b0}, 26'h0, 1'b1, 0));
    else         checkOutput("mult_gone", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));

    // Asynchronous reset in the middle of draining
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADD_W, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_issue", mkExp(5'b10000, 4'h2, 32'h0, {5'd1, 5'd2, 5'd3, 1'b1}, 26'h0, 1'b1, 2));
    #2 Rst_n = 1'b0;
    #1 checkOutput("reset_mid_drain", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));
    @(negedge Clk);
    Rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_reset_empty", mkExp(5'b0, 4'h0, 32'h0, 16'h0, 26'h0, 1'b1, 0));

    model_q.delete();
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      ifl = ($urandom_range(0, 2) == 0);
      lfl = ($urandom_range(0, 2) == 0);
      mfl = ($urandom_range(0, 2) == 0);
      w   = genInst();
      modelStep(v, w, fl, ifl, lfl, mfl, e);
      applyStimulus(v, w, fl, ifl, lfl, mfl);
      checkOutput("random", e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/decode_dispatch.md
# decode_dispatch

Buffered, back-pressure-aware successor of the instruction decoder. It accepts 32-bit MIPS-subset instructions over a valid/ready handshake into a parametrised FIFO, decodes the head entry, and issues it to the Int, LS or Mult issue queue. Issue is held while the target queue reports full. It sits between instruction fetch and the three issue queues, and adds register-field extraction, correct immediate extension, jump and illegal-instruction reporting, and flush.

## Interface
- IBUF_DEPTH, 4: instruction buffer entries; power of 2, ≥2.
- CNT_W, $clog2(IBUF_DEPTH)+1: occupancy counter width.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous; empties buffer, suppresses issue this cycle.
- Inst  in  32  instruction word.
- Inst_Valid  in  1  Inst is valid.
- Inst_Ready  out  1  buffer can accept; = (count < IBUF_DEPTH), combinational.
- Int_Full, LS_Full, Mult_Full  in  1 each  target queue cannot accept.
- Dispatch_Opcode  out  4  ALU/LS opcode.
- Dispatch_Shfamt  out  5  Inst[10:6] for R-type, else 0.
- Dispatch_Imm_LS  out  32  extended immediate.
- Dispatch_Rs, Dispatch_Rt  out  5 each  source registers.
- Dispatch_Rd  out  5  destination: Inst[15:11] R-type, Inst[20:16] I-type writers.
- Dispatch_Rd_Wr  out  1  instruction writes Dispatch_Rd (0 for BEQ/BNQ/STW/J/MULT).
- Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult  out  1 each  one-cycle issue strobes.
- Dispatch_Jmp  out  1  jump strobe; Dispatch_Jmp_Addr  out  26  Inst[25:0].
- Illegal_Inst  out  1  one-cycle strobe on undecodable head.
- Buf_Count  out  CNT_W  current occupancy.

## Operation
- Push: Inst_Valid && Inst_Ready && !Flush writes Inst at wr_ptr. Pointers wrap modulo IBUF_DEPTH.
- Head decode (combinational, from rd_ptr) selects a target queue and fields.
- R-type (op 0x00) funct mapping: ADD 0x20→2, ADDU 0x21→3, SUB 0x22→6, AND 0x24→0, OR 0x25→1, NOR 0x27→C, SLT 0x2A→7, SLTU 0x2B→A, SLL 0x00→8, SRL 0x02→9; all target Int. MULT 0x18→opcode 0, target Mult.
- I-type: ADDI 0x08→2, ADDIU 0x09→3, SLTI 0x0A→7, BEQ 0x04→4, BNQ 0x05→5 are sign-extended, target Int. ANDI 0x0C→0 and ORI 0x0D→1 are zero-extended, target Int. LDW 0x23→1 and STW 0x2B→0 are sign-extended, target LS.
- J 0x02: no queue; Dispatch_Jmp=1 with address.
- Any other opcode or funct: illegal; Illegal_Inst=1, no enable.
- Pop occurs when buffer non-empty, !Flush, and (target full flag = 0 or target is none, i.e. J or illegal). On pop, all outputs register the decoded values.
- Stall (target full): head retained, no pop, all outputs return to defaults.
- Defaults, whenever no pop: every output 0 except Inst_Ready and Buf_Count.
- Simultaneous push and pop: count unchanged. Push is refused at count==IBUF_DEPTH even if a pop occurs the same cycle.
- Flush: pointers and count to 0, outputs to defaults next edge; a concurrent push is dropped.

## Timing
- Reset (Rst_n low, asynchronous): pointers, count, and all registered outputs = 0. Inst_Ready = 1 after reset.
- Latency: instruction pushed at edge k is issued (strobe visible) after edge k+1 at earliest. There is no same-cycle bypass.
- Throughput: one issue per cycle while the buffer is non-empty and targets are not full.
- Strobes are exactly one cycle per instruction. Back-to-back instructions give consecutive strobes.
- A full flag sampled high at an edge blocks that edge's pop only. Issue resumes the edge after the flag drops.
- Rst_n asserted mid-stream discards all buffered instructions immediately.

## Configuration
- DECODE_MULT_EN defined: MULT decodes as above and is gated by Mult_Full. Dispatch_en_Mult is live.
- DECODE_MULT_EN undefined: funct 0x18 is illegal (Illegal_Inst strobe, popped). Mult_Full is ignored and Dispatch_en_Mult is tied 0.

## Test plan
- Reset, then push ADD $3,$1,$2 (0x00221820) → next cycle en_Int=1, Opcode=2, Rs=1, Rt=2, Rd=3, Rd_Wr=1. All outputs were 0 during reset.
- ADDI with imm 0xFFFC → Imm_LS=0xFFFFFFFC. ORI with imm 0xFFFC → Imm_LS=0x0000FFFC.
- Fill 4 LDW while LS_Full=1 → Buf_Count=4, Inst_Ready=0, no en_LS. Release LS_Full → 4 consecutive en_LS strobes, count drains to 0.
- J 0x0000100 → Dispatch_Jmp=1, Jmp_Addr=0x0000100, no enables. Opcode 0x3F → Illegal_Inst one cycle, entry popped.
- Flush with 3 entries queued plus a concurrent push → Buf_Count=0 next cycle, no strobes. Rst_n pulsed mid-drain → outputs 0 asynchronously.
- MULT (funct 0x18) → en_Mult=1 with DECODE_MULT_EN defined. Without the macro → Illegal_Inst=1, en_Mult=0.
